// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package mem_arb_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      IDLE,
      EXT_BURST
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_EXT
   } arb_owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr and inc together restart the count at 1.
module sat_counter #(
   parameter int unsigned MAX = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       inc,
   input  logic                       clr,
   output logic [$clog2(MAX+1)-1:0]   cnt
);

   localparam int unsigned W = $clog2(MAX + 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? W'(1) : '0;
      end else if (inc && (cnt != W'(MAX))) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and an external
// loader/DMA port, with bounded ext bursts and ext starvation protection.
module dmem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned MAX_BURST    = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [XLEN-1:0] cpu_addr,
   input  logic [XLEN-1:0] cpu_wdata,
   output logic            cpu_gnt,
   output logic            cpu_rvalid,
   output logic [XLEN-1:0] cpu_rdata,
   input  logic            ext_req,
   input  logic            ext_we,
   input  logic [XLEN-1:0] ext_addr,
   input  logic [XLEN-1:0] ext_wdata,
   input  logic            ext_last,
   output logic            ext_gnt,
   output logic            ext_rvalid,
   output logic [XLEN-1:0] ext_rdata,
   output logic            mem_write_en,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   arb_state_t    state_q, state_d;
   arb_owner_t    owner;
   logic [SW-1:0] starve_cnt;
   logic [BW-1:0] beat_cnt;
   logic          beat_inc, beat_clr;
   logic          starve_hit, beat_hit;

   assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
   assign beat_hit   = (beat_cnt == BW'(MAX_BURST));

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Grant selection and burst tracking; nothing is granted during reset.
   always_comb begin
      state_d  = state_q;
      owner    = OWN_NONE;
      beat_inc = 1'b0;
      beat_clr = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (ext_req && starve_hit) owner = OWN_EXT;
               else if (cpu_req)          owner = OWN_CPU;
               else if (ext_req)          owner = OWN_EXT;
               if ((owner == OWN_EXT) && !ext_last) begin
                  state_d  = EXT_BURST;
                  beat_clr = 1'b1;
                  beat_inc = 1'b1;
               end
            end
            EXT_BURST: begin
               if (ext_req) begin
                  if (beat_hit && cpu_req) begin
                     owner   = OWN_CPU;
                     state_d = IDLE;
                  end else begin
                     owner    = OWN_EXT;
                     beat_inc = 1'b1;
                     if (ext_last) state_d = IDLE;
                  end
               end else if (cpu_req) begin
                  owner = OWN_CPU;
               end
            end
         endcase
      end
   end

   assign cpu_gnt = (owner == OWN_CPU);
   assign ext_gnt = (owner == OWN_EXT);

   sat_counter #(.MAX(STARVE_LIMIT)) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ext_req & ~ext_gnt),
      .clr   (ext_gnt),
      .cnt   (starve_cnt)
   );

   sat_counter #(.MAX(MAX_BURST)) u_beat_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (beat_inc),
      .clr   (beat_clr),
      .cnt   (beat_cnt)
   );

   // Idle port defaults to the CPU's address/data with writes disabled.
   assign mem_addr     = ext_gnt ? ext_addr  : cpu_addr;
   assign mem_wdata    = ext_gnt ? ext_wdata : cpu_wdata;
   assign mem_write_en = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         ext_rvalid <= 1'b0;
         ext_rdata  <= '0;
      end else begin
         cpu_rvalid <= cpu_gnt & ~cpu_we;
         ext_rvalid <= ext_gnt & ~ext_we;
         if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rdata;
         if (ext_gnt && !ext_we) ext_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;

   localparam int unsigned STARVE = 4;
   localparam int unsigned MAXB   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        ext_req, ext_we, ext_last, ext_gnt, ext_rvalid;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        mem_write_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        init_en;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(STARVE), .MAX_BURST(MAXB)) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_gnt      (cpu_gnt),
      .cpu_rvalid   (cpu_rvalid),
      .cpu_rdata    (cpu_rdata),
      .ext_req      (ext_req),
      .ext_we       (ext_we),
      .ext_addr     (ext_addr),
      .ext_wdata    (ext_wdata),
      .ext_last     (ext_last),
      .ext_gnt      (ext_gnt),
      .ext_rvalid   (ext_rvalid),
      .ext_rdata    (ext_rdata),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   function automatic logic [31:0] init_val(input int i);
      return (i == 4) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(i));
   endfunction

   // Data memory driven by the DUT's port.
   logic [31:0] tb_mem [256];
   assign mem_rdata = tb_mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
      end else if (mem_write_en) begin
         tb_mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model state.
   logic [31:0] ref_mem [256];
   bit          m_burst;
   int          m_starve, m_beat;
   bit          exp_cv, exp_ev;
   logic [31:0] exp_cd, exp_ed;

   // Requester driver state.
   bit          c_pend, c_we;
   logic [31:0] c_addr, c_wdata;
   bit          e_pend, e_we, e_allstore;
   logic [31:0] e_addr, e_wdata;
   int          e_left, e_gap, e_done;
   bit          obs_cg, obs_eg;

   function automatic logic [31:0] rnd_addr();
      return {22'd0, 8'($urandom), 2'b00};
   endfunction

   task automatic new_cpu(input bit we, input logic [31:0] a, input logic [31:0] d);
      c_pend = 1'b1; c_we = we; c_addr = a; c_wdata = d;
   endtask

   task automatic tick(input bit rst);
      bit gc, ge, last;
      @(negedge clk);
      if (!e_pend && e_left > 0) begin
         if (e_gap > 0) begin
            e_gap--;
         end else begin
            e_pend  = 1'b1;
            e_we    = e_allstore ? 1'b1 : 1'($urandom);
            e_addr  = rnd_addr();
            e_wdata = $urandom;
         end
      end
      last      = (e_left == 1);
      reset     = rst;
      cpu_req   = c_pend;  cpu_we = c_we;  cpu_addr = c_addr;  cpu_wdata = c_wdata;
      ext_req   = e_pend;  ext_we = e_we;  ext_addr = e_addr;  ext_wdata = e_wdata;
      ext_last  = last;
      #1;
      gc = 1'b0; ge = 1'b0;
      if (!rst) begin
         if (!m_burst) begin
            if (e_pend && m_starve == STARVE) ge = 1'b1;
            else if (c_pend)                  gc = 1'b1;
            else if (e_pend)                  ge = 1'b1;
         end else if (e_pend) begin
            if (m_beat == MAXB && c_pend) gc = 1'b1;
            else                          ge = 1'b1;
         end else begin
            gc = c_pend;
         end
      end
      check("cpu_gnt", 32'(cpu_gnt), 32'(gc));
      check("ext_gnt", 32'(ext_gnt), 32'(ge));
      check("mem_write_en", 32'(mem_write_en), 32'((gc && c_we) || (ge && e_we)));
      if (gc || ge) check("mem_addr", mem_addr, ge ? e_addr : c_addr);
      if ((gc && c_we) || (ge && e_we)) check("mem_wdata", mem_wdata, ge ? e_wdata : c_wdata);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
      check("cpu_rdata", cpu_rdata, exp_cd);
      check("ext_rvalid", 32'(ext_rvalid), 32'(exp_ev));
      check("ext_rdata", ext_rdata, exp_ed);
      obs_cg = cpu_gnt;
      obs_eg = ext_gnt;
      @(posedge clk);
      if (rst) begin
         m_burst = 1'b0; m_starve = 0; m_beat = 0;
         exp_cv = 1'b0; exp_ev = 1'b0; exp_cd = '0; exp_ed = '0;
         c_pend = 1'b0; e_pend = 1'b0; e_left = 0; e_gap = 0;
      end else begin
         exp_cv = gc && !c_we;
         exp_ev = ge && !e_we;
         if (exp_cv) exp_cd = ref_mem[c_addr[9:2]];
         if (exp_ev) exp_ed = ref_mem[e_addr[9:2]];
         if (gc && c_we) ref_mem[c_addr[9:2]] = c_wdata;
         if (ge && e_we) ref_mem[e_addr[9:2]] = e_wdata;
         if (ge) m_starve = 0;
         else if (e_pend && m_starve < STARVE) m_starve++;
         if (!m_burst) begin
            if (ge && !last) begin m_burst = 1'b1; m_beat = 1; end
         end else if (ge) begin
            if (m_beat < MAXB) m_beat++;
            if (last) m_burst = 1'b0;
         end else if (e_pend && gc) begin
            m_burst = 1'b0;
         end
         if (gc) c_pend = 1'b0;
         if (ge) begin e_pend = 1'b0; e_left--; e_done++; end
      end
   endtask

   initial begin
      int n, k, cpu_at, n_ext, n_cg;
      bit gap_set;
      reset = 1'b1; init_en = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_last = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      c_pend = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      e_pend = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_left = 0; e_gap = 0; e_done = 0; e_allstore = 0;
      repeat (3) @(posedge clk);
      init_en = 1'b0;

      // Reset state, then a single CPU load.
      tick(1'b1);
      new_cpu(1'b0, 32'h10, '0);
      tick(1'b0);
      #1;
      check("load_rvalid", 32'(cpu_rvalid), 32'd1);
      check("load_rdata", cpu_rdata, 32'hDEADBEEF);
      check("load_ext_rvalid", 32'(ext_rvalid), 32'd0);

      // Both requesters storing continuously: C,C,C,C,E pattern.
      n_ext = 0; k = 0;
      for (int i = 1; i <= 15; i++) begin
         if (!c_pend) new_cpu(1'b1, rnd_addr(), $urandom);
         if (e_left == 0) begin e_left = 1; e_allstore = 1; end
         tick(1'b0);
         if (obs_eg) begin n_ext++; k = i; end
      end
      check("starve_ext_count", 32'(n_ext), 32'd3);
      check("starve_last_ext", 32'(k), 32'd15);
      tick(1'b0);

      // 12-beat store burst, CPU load arriving at beat 3 preempts at MAX_BURST.
      e_left = 12; e_allstore = 1; e_done = 0; c_pend = 0;
      n = 0; cpu_at = 0;
      while (e_left > 0 && n < 40) begin
         if (e_done == 2 && cpu_at == 0 && !c_pend) new_cpu(1'b0, rnd_addr(), '0);
         tick(1'b0);
         n++;
         if (obs_cg) cpu_at = n;
      end
      check("preempt_cycle", 32'(cpu_at), 32'd9);
      check("burst_cycles", 32'(n), 32'd13);
      tick(1'b0);

      // Burst with a 2-cycle ext gap while the CPU keeps requesting.
      e_left = 6; e_allstore = 1; e_done = 0; gap_set = 0; n = 0; n_cg = 0;
      while (e_left > 0 && n < 40) begin
         if (e_done == 2 && !gap_set) begin e_gap = 2; gap_set = 1; end
         if (e_done >= 2 && e_done < 4 && !c_pend) new_cpu(1'b0, rnd_addr(), '0);
         tick(1'b0);
         n++;
         if (obs_cg) n_cg++;
      end
      check("gap_cpu_grants", 32'(n_cg), 32'd2);
      check("gap_burst_cycles", 32'(n), 32'd8);
      n = 0;
      while (c_pend && n < 20) begin tick(1'b0); n++; end
      check("gap_cpu_drain", 32'(c_pend), 32'd0);

      // Reset at beat 3 of a store burst, then a single ext store.
      e_left = 6; e_allstore = 1; e_done = 0; n = 0;
      while (e_done < 2 && n < 20) begin tick(1'b0); n++; end
      tick(1'b1);
      e_left = 1; e_allstore = 1;
      tick(1'b0);
      check("post_reset_ext_gnt", 32'(obs_eg), 32'd1);

      // Ext store 0x55 to 0x20, then CPU load from 0x20.
      e_pend = 1; e_we = 1; e_addr = 32'h20; e_wdata = 32'h55; e_left = 1;
      n = 0;
      while (e_pend && n < 10) begin tick(1'b0); n++; end
      new_cpu(1'b0, 32'h20, '0);
      tick(1'b0);
      #1;
      check("store_then_load", cpu_rdata, 32'h55);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         if (!c_pend && ((i < 1500) || ($urandom % 3 == 0)))
            new_cpu(1'($urandom), rnd_addr(), $urandom);
         if (e_left == 0 && !e_pend && ($urandom % 6 == 0)) begin
            e_left = $urandom_range(1, 14); e_allstore = 0; e_done = 0;
         end
         if (!e_pend && e_left > 0 && e_gap == 0 && ($urandom % 5 == 0))
            e_gap = $urandom_range(1, 2);
         tick(($urandom % 200) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
